// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX byte stream between two requesters.
// A requester owns the UART until it transfers EOP_CHAR or stays idle for
// TIMEOUT_CYCLES consecutive cycles. Ties are resolved round-robin.
// The datapath is a combinational mux selected by the registered owner state.
module uart_tx_arbiter #(
  parameter logic [7:0]  EOP_CHAR       = 8'h0A,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_owner;
  logic             last_owner_nxt;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_cnt_nxt;
  logic             own_valid;
  logic [7:0]       own_data;
  logic             release_own;

  // State, round-robin history and owner-idle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      idle_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      idle_cnt   <= idle_cnt_nxt;
    end
  end

  // Owner mux, release detection and next-state selection.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    idle_cnt_nxt   = '0;
    own_valid      = 1'b0;
    own_data       = 8'h00;
    release_own    = 1'b0;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;

    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          // last_owner==1 means requester 0 is next in line.
          state_nxt = last_owner ? OWN0 : OWN1;
        end else if (req0_valid) begin
          state_nxt = OWN0;
        end else if (req1_valid) begin
          state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (state == OWN0) begin
          own_valid  = req0_valid;
          own_data   = req0_data;
          req0_ready = tx_ready;
        end else begin
          own_valid  = req1_valid;
          own_data   = req1_data;
          req1_ready = tx_ready;
        end
        // Backpressured bytes keep the counter cleared; only a silent owner ages.
        if (own_valid) begin
          release_own = tx_ready && (own_data == EOP_CHAR);
        end else if (idle_cnt == CNT_LAST) begin
          release_own = 1'b1;
        end else begin
          idle_cnt_nxt = idle_cnt + CNT_W'(1);
        end
        if (release_own) begin
          state_nxt      = IDLE;
          last_owner_nxt = (state == OWN1);
          idle_cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    tx_valid = own_valid;
    tx_data  = own_data;
  end

  assign grant = 2'(state);
  assign busy  = |grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-scenario tasks plus a byte scoreboard.
// Bytes are queued per requester when driven; the monitor pops and compares
// each byte that actually crosses the tx interface.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [1:0] grant;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  uart_tx_arbiter #(
    .EOP_CHAR      (8'h0A),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted byte must be the oldest pending byte of the owner.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && tx_valid && tx_ready) begin
        n_vec++;
        if (grant == 2'b01 && q0.size() > 0) begin
          exp_b = q0.pop_front();
          if (tx_data !== exp_b) begin
            n_err++;
            $display("FAIL sb_req0 t=%0t got=%h exp=%h", $time, tx_data, exp_b);
          end
        end else if (grant == 2'b10 && q1.size() > 0) begin
          exp_b = q1.pop_front();
          if (tx_data !== exp_b) begin
            n_err++;
            $display("FAIL sb_req1 t=%0t got=%h exp=%h", $time, tx_data, exp_b);
          end
        end else begin
          n_err++;
          $display("FAIL sb_unexpected t=%0t grant=%b data=%h q0=%0d q1=%0d",
                   $time, grant, tx_data, q0.size(), q1.size());
        end
      end
    end
  end

  // Global time bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put0(input logic [7:0] b);
    req0_valid = 1'b1;
    req0_data  = b;
    q0.push_back(b);
  endtask

  task automatic put1(input logic [7:0] b);
    req1_valid = 1'b1;
    req1_data  = b;
    q1.push_back(b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_data = 8'h00;
    tx_ready = 1'b0;
    tick(); tick();
    #1;
    n_vec++;
    if (grant !== 2'b00 || busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
        req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got grant=%b busy=%b txv=%b txd=%h r0=%b r1=%b exp all zero",
               grant, busy, tx_valid, tx_data, req0_ready, req1_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_packet();
    tick(); put0(8'h41); put1(8'h5A); tx_ready = 1'b1; #1;
    n_vec++;
    if (grant !== 2'b00) begin n_err++; $display("FAIL basic_latency got=%b exp=00", grant); end
    tick(); #1;
    n_vec++;
    if (grant !== 2'b01 || busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h41 ||
        req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_grant0 got grant=%b busy=%b txv=%b txd=%h r0=%b r1=%b exp 01/1/1/41/1/0",
               grant, busy, tx_valid, tx_data, req0_ready, req1_ready);
    end
    tick(); put0(8'h42); #1;
    n_vec++;
    if (tx_data !== 8'h42 || req1_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_b1 got txd=%h r1=%b exp 42/0", tx_data, req1_ready);
    end
    tick(); put0(8'h0A); #1;
    n_vec++;
    if (tx_data !== 8'h0A || grant !== 2'b01 || req1_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_eop got txd=%h grant=%b r1=%b exp 0a/01/0", tx_data, grant, req1_ready);
    end
    tick(); req0_valid = 1'b0; #1;
    n_vec++;
    if (grant !== 2'b00 || req1_ready !== 1'b0 || tx_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_gap got grant=%b r1=%b txv=%b exp 00/0/0", grant, req1_ready, tx_valid);
    end
    tick(); #1;
    n_vec++;
    if (grant !== 2'b10 || tx_data !== 8'h5A || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_grant1 got grant=%b txd=%h r1=%b r0=%b exp 10/5a/1/0",
                        grant, tx_data, req1_ready, req0_ready);
    end
    tick(); put1(8'h0A); #1;
  endtask

  task automatic test_round_robin();
    // req1 just finished: tie goes to req0.
    tick(); put0(8'h31); put1(8'h32); #1;
    n_vec++;
    if (grant !== 2'b00) begin n_err++; $display("FAIL rr_gap1 got=%b exp=00", grant); end
    tick(); #1;
    n_vec++;
    if (grant !== 2'b01 || tx_data !== 8'h31) begin
      n_err++; $display("FAIL rr_tie_req0 got grant=%b txd=%h exp 01/31", grant, tx_data);
    end
    tick(); put0(8'h0A); #1;
    // req0 re-requests immediately after release and must lose to waiting req1.
    tick(); put0(8'h33); #1;
    n_vec++;
    if (grant !== 2'b00) begin n_err++; $display("FAIL rr_gap2 got=%b exp=00", grant); end
    tick(); #1;
    n_vec++;
    if (grant !== 2'b10 || tx_data !== 8'h32 || req0_ready !== 1'b0) begin
      n_err++; $display("FAIL rr_tie_req1 got grant=%b txd=%h r0=%b exp 10/32/0", grant, tx_data, req0_ready);
    end
    tick(); put1(8'h0A); #1;
    tick(); req1_valid = 1'b0; #1;
    n_vec++;
    if (grant !== 2'b00) begin n_err++; $display("FAIL rr_gap3 got=%b exp=00", grant); end
    tick(); #1;
    n_vec++;
    if (grant !== 2'b01 || tx_data !== 8'h33) begin
      n_err++; $display("FAIL rr_waiting_req0 got grant=%b txd=%h exp 01/33", grant, tx_data);
    end
    tick(); put0(8'h0A); #1;
    tick(); req0_valid = 1'b0; #1;
  endtask

  task automatic test_timeout();
    tick(); put0(8'h58); #1;
    tick(); #1;
    n_vec++;
    if (grant !== 2'b01 || tx_data !== 8'h58) begin
      n_err++; $display("FAIL to_grant got grant=%b txd=%h exp 01/58", grant, tx_data);
    end
    tick(); req0_valid = 1'b0; put1(8'h77);
    for (int i = 0; i < 16; i++) begin
      #1;
      n_vec++;
      if (grant !== 2'b01 || req1_ready !== 1'b0) begin
        n_err++; $display("FAIL to_hold idle=%0d got grant=%b r1=%b exp 01/0", i, grant, req1_ready);
      end
      tick();
    end
    #1;
    n_vec++;
    if (grant !== 2'b00) begin n_err++; $display("FAIL to_release got=%b exp=00", grant); end
    tick(); #1;
    n_vec++;
    if (grant !== 2'b10 || tx_data !== 8'h77) begin
      n_err++; $display("FAIL to_next got grant=%b txd=%h exp 10/77", grant, tx_data);
    end
    tick(); put1(8'h0A); #1;
    tick(); req1_valid = 1'b0; #1;
  endtask

  task automatic test_backpressure();
    tx_ready = 1'b0;
    tick(); put0(8'h55); #1;
    tick();
    for (int i = 0; i < 50; i++) begin
      #1;
      n_vec++;
      if (grant !== 2'b01 || tx_valid !== 1'b1 || tx_data !== 8'h55 || req0_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_stall cyc=%0d got grant=%b txv=%b txd=%h r0=%b exp 01/1/55/0",
                          i, grant, tx_valid, tx_data, req0_ready);
      end
      tick();
    end
    tx_ready = 1'b1; #1;
    n_vec++;
    if (req0_ready !== 1'b1 || tx_data !== 8'h55) begin
      n_err++; $display("FAIL bp_accept got r0=%b txd=%h exp 1/55", req0_ready, tx_data);
    end
    tick(); put0(8'h0A); #1;
    tick(); req0_valid = 1'b0; #1;
    n_vec++;
    if (grant !== 2'b00) begin n_err++; $display("FAIL bp_release got=%b exp=00", grant); end
  endtask

  task automatic test_non_owner_block();
    tick(); put0(8'h71); #1;
    tick(); put1(8'h62); #1;
    n_vec++;
    if (grant !== 2'b01 || req1_ready !== 1'b0) begin
      n_err++; $display("FAIL nob_start got grant=%b r1=%b exp 01/0", grant, req1_ready);
    end
    for (int b = 8'h72; b <= 8'h75; b++) begin
      tick(); put0(8'(b)); #1;
      n_vec++;
      if (grant !== 2'b01 || req1_ready !== 1'b0) begin
        n_err++; $display("FAIL nob_stream byte=%h got grant=%b r1=%b exp 01/0", b, grant, req1_ready);
      end
    end
    tick(); put0(8'h0A); #1;
    tick(); req0_valid = 1'b0; #1;
    n_vec++;
    if (grant !== 2'b00 || req1_ready !== 1'b0) begin
      n_err++; $display("FAIL nob_gap got grant=%b r1=%b exp 00/0", grant, req1_ready);
    end
    tick(); #1;
    n_vec++;
    if (grant !== 2'b10 || tx_data !== 8'h62) begin
      n_err++; $display("FAIL nob_grant1 got grant=%b txd=%h exp 10/62", grant, tx_data);
    end
    tick(); put1(8'h0A); #1;
    tick(); req1_valid = 1'b0; #1;
  endtask

  task automatic test_reset_mid_packet();
    tick(); put1(8'h81); #1;
    tick(); #1;
    n_vec++;
    if (grant !== 2'b10) begin n_err++; $display("FAIL rmp_own1 got=%b exp=10", grant); end
    tick(); put1(8'h82); rst = 1'b1; tx_ready = 1'b0; #1;
    tick(); #1;
    n_vec++;
    if (grant !== 2'b00 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rmp_reset got grant=%b txv=%b busy=%b exp 00/0/0", grant, tx_valid, busy);
    end
    // The truncated packet is dropped; req1 keeps holding 0x82 afterwards.
    q1.delete();
    rst = 1'b0; tx_ready = 1'b1;
    put0(8'h91); put1(8'h82);
    tick(); #1;
    n_vec++;
    if (grant !== 2'b01 || tx_data !== 8'h91) begin
      n_err++; $display("FAIL rmp_after got grant=%b txd=%h exp 01/91", grant, tx_data);
    end
    tick(); put0(8'h0A); #1;
    tick(); req0_valid = 1'b0; #1;
    tick(); #1;
    n_vec++;
    if (grant !== 2'b10 || tx_data !== 8'h82) begin
      n_err++; $display("FAIL rmp_req1 got grant=%b txd=%h exp 10/82", grant, tx_data);
    end
    tick(); put1(8'h0A); #1;
    tick(); req1_valid = 1'b0; #1;
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_non_owner_block();
    test_reset_mid_packet();
    tick(); #3;
    n_vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++; $display("FAIL sb_drain got q0=%0d q1=%0d exp 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
